// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-access stage.
//   - bus widths of the pipeline
//   - funct3 load/store size codes
//   - memory-stage FSM state encoding
package mem_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int INST_BUS     = 32;
    localparam int MEM_ADDR_BUS = 32;

    // funct3 codes shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;   // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;   // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;   // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;   // LBU
    localparam logic [2:0] F3_HU = 3'b101;   // LHU

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // accepting a new slot, bus outputs driven from inputs
        ST_WAIT_R = 2'd1,   // load granted, waiting for read data
        ST_DRAIN  = 2'd2    // load was flushed, swallow its read data
    } mem_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: purely combinational load/store lane handling.
// Ports:
//   funct3, we, offset, din -> be, wdata, misalign  (current request)
//   ld_funct3, ld_offset, rdata -> ld_data          (returning load data)
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]         funct3,
    input  logic               we,
    input  logic [1:0]         offset,
    input  logic [REG_BUS-1:0] din,
    output logic [3:0]         be,
    output logic [REG_BUS-1:0] wdata,
    output logic               misalign,
    input  logic [2:0]         ld_funct3,
    input  logic [1:0]         ld_offset,
    input  logic [REG_BUS-1:0] rdata,
    output logic [REG_BUS-1:0] ld_data
);

    logic [REG_BUS-1:0] shifted;

    // Request side: lane enables, replicated store data, legality check.
    always_comb begin
        be       = 4'b1111;
        wdata    = din;
        misalign = 1'b0;
        case (funct3)
            F3_B: begin
                if (we) begin
                    be    = 4'b0001 << offset;
                    wdata = {4{din[7:0]}};
                end
            end
            F3_H: begin
                misalign = offset[0];
                if (we) begin
                    be    = 4'b0011 << offset;
                    wdata = {2{din[15:0]}};
                end
            end
            F3_W: misalign = (offset != 2'b00);
            // There is no unsigned store, so these codes are illegal for stores.
            F3_BU: misalign = we;
            F3_HU: misalign = we | offset[0];
            default: misalign = 1'b1;
        endcase
    end

    // Response side: move the addressed lane down, then extend.
    always_comb begin
        shifted = rdata >> {ld_offset, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'd0, shifted[7:0]};
            F3_HU:   ld_data = {16'd0, shifted[15:0]};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem.sv
// mem: memory-access stage with the MEM/WB register.
// Ports:
//   clk, rstn (sync, active-high)         clock / reset
//   valid_i .. flush_i                     EX/MEM slot
//   ready_o                                upstream advance (0 = stall)
//   dbus_*                                 req/gnt/rvalid data bus, one outstanding load
//   valid_o .. misalign_o                  registered MEM/WB slot
// Handshake: dbus_req_o is raised only in IDLE and held, with the slot stable,
// until dbus_gnt_i. A granted load then waits for exactly one dbus_rvalid_i.
// ready_o=1 means the current EX/MEM slot is consumed at this clock edge.
module mem
    import mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    valid_i,
    input  logic [INST_BUS-1:0]     inst_i,
    input  logic [MEM_ADDR_BUS-1:0] instaddr_i,
    input  logic                    cs_i,
    input  logic                    mem_we_i,
    input  logic [MEM_ADDR_BUS-1:0] mem_addr_i,
    input  logic [REG_BUS-1:0]      mem_din_i,
    input  logic                    regs_wen_i,
    input  logic [REG_ADDR_BUS-1:0] rd_addr_i,
    input  logic [REG_BUS-1:0]      rd_data_i,
    input  logic                    flush_i,
    output logic                    ready_o,
    output logic                    dbus_req_o,
    output logic                    dbus_we_o,
    output logic [3:0]              dbus_be_o,
    output logic [MEM_ADDR_BUS-1:0] dbus_addr_o,
    output logic [REG_BUS-1:0]      dbus_wdata_o,
    input  logic                    dbus_gnt_i,
    input  logic                    dbus_rvalid_i,
    input  logic [REG_BUS-1:0]      dbus_rdata_i,
    output logic                    valid_o,
    output logic [INST_BUS-1:0]     inst_o,
    output logic [MEM_ADDR_BUS-1:0] instaddr_o,
    output logic                    regs_wen_o,
    output logic [REG_ADDR_BUS-1:0] rd_addr_o,
    output logic [REG_BUS-1:0]      rd_data_o,
    output logic                    misalign_o
);

    mem_state_e         state, state_nxt;
    logic [2:0]         ld_f3_q;
    logic [1:0]         ld_off_q;
    logic               mis;
    logic [REG_BUS-1:0] ld_data;

    // MEM/WB update controls produced by the FSM
    logic               take_valid, take_wen, take_mis, take_fields, ld_latch;
    logic [REG_BUS-1:0] take_data;

    lsu_align u_align (
        .funct3    (inst_i[14:12]),
        .we        (mem_we_i),
        .offset    (mem_addr_i[1:0]),
        .din       (mem_din_i),
        .be        (dbus_be_o),
        .wdata     (dbus_wdata_o),
        .misalign  (mis),
        .ld_funct3 (ld_f3_q),
        .ld_offset (ld_off_q),
        .rdata     (dbus_rdata_i),
        .ld_data   (ld_data)
    );

    assign dbus_we_o   = mem_we_i;
    assign dbus_addr_o = {mem_addr_i[31:2], 2'b00};
    assign dbus_req_o  = valid_i & cs_i & ~mis & ~flush_i & (state == ST_IDLE);

    always_comb begin
        state_nxt   = state;
        ready_o     = 1'b0;
        take_valid  = 1'b0;
        take_wen    = 1'b0;
        take_mis    = 1'b0;
        take_fields = 1'b0;
        take_data   = rd_data_i;
        ld_latch    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!valid_i || flush_i) begin
                    ready_o = 1'b1;                 // slot retires as a bubble
                end else if (!cs_i) begin
                    ready_o     = 1'b1;
                    take_valid  = 1'b1;
                    take_wen    = regs_wen_i;
                    take_fields = 1'b1;
                end else if (mis) begin
                    ready_o     = 1'b1;
                    take_valid  = 1'b1;
                    take_mis    = 1'b1;
                    take_fields = 1'b1;
                end else if (dbus_gnt_i) begin
                    if (mem_we_i) begin
                        ready_o     = 1'b1;
                        take_valid  = 1'b1;
                        take_fields = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT_R;
                        ld_latch  = 1'b1;
                    end
                end
            end
            ST_WAIT_R: begin
                if (flush_i) begin
                    // Data arriving together with the flush is simply dropped.
                    state_nxt = dbus_rvalid_i ? ST_IDLE : ST_DRAIN;
                end else if (dbus_rvalid_i) begin
                    state_nxt   = ST_IDLE;
                    ready_o     = 1'b1;
                    take_valid  = 1'b1;
                    take_wen    = regs_wen_i;
                    take_fields = 1'b1;
                    take_data   = ld_data;
                end
            end
            ST_DRAIN: begin
                if (dbus_rvalid_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state      <= ST_IDLE;
            ld_f3_q    <= 3'd0;
            ld_off_q   <= 2'd0;
            valid_o    <= 1'b0;
            regs_wen_o <= 1'b0;
            misalign_o <= 1'b0;
            inst_o     <= '0;
            instaddr_o <= '0;
            rd_addr_o  <= '0;
            rd_data_o  <= '0;
        end else begin
            state      <= state_nxt;
            valid_o    <= take_valid;
            regs_wen_o <= take_wen;
            misalign_o <= take_mis;
            if (ld_latch) begin
                ld_f3_q  <= inst_i[14:12];
                ld_off_q <= mem_addr_i[1:0];
            end
            if (take_fields) begin
                inst_o     <= inst_i;
                instaddr_o <= instaddr_i;
                rd_addr_o  <= rd_addr_i;
                rd_data_o  <= take_data;
            end
        end
    end

endmodule

// File: tb/tb_mem.sv
// tb_mem: randomized scoreboard bench for the memory-access stage.
module tb_mem;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_i, cs_i, mem_we_i, regs_wen_i, flush_i;
    logic [31:0] inst_i, instaddr_i, mem_addr_i, mem_din_i, rd_data_i;
    logic [4:0]  rd_addr_i;
    logic        ready_o, dbus_req_o, dbus_we_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic        dbus_gnt_i, dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic        valid_o, regs_wen_o, misalign_o;
    logic [31:0] inst_o, instaddr_o, rd_data_o;
    logic [4:0]  rd_addr_o;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] iaddr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mem dut (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .inst_i(inst_i),
        .instaddr_i(instaddr_i), .cs_i(cs_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_din_i(mem_din_i), .regs_wen_i(regs_wen_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .flush_i(flush_i),
        .ready_o(ready_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
        .dbus_be_o(dbus_be_o), .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
        .valid_o(valid_o), .inst_o(inst_o), .instaddr_o(instaddr_o),
        .regs_wen_o(regs_wen_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .misalign_o(misalign_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic we, input logic [31:0] a);
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return !legal || ((a % size_of(f3)) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic we, input logic [31:0] a);
        int sz;
        if (!we) return 4'hF;
        sz = size_of(f3);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (size_of(f3))
            1:       return {24'd0, d[7:0]} * 32'h0101_0101;
            2:       return {16'd0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        int          sz;
        logic [31:0] v, m;
        sz = size_of(f3);
        if (sz == 4) return rdata;
        v = rdata >> (8 * (a % 4));
        m = (32'd1 << (8 * sz)) - 1;
        v = v & m;
        if (!f3[2] && v[8*sz-1]) v = v | ~m;
        return v;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid MEM/WB slot must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid_o", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("inst_o", inst_o, e.inst);
                chk("instaddr_o", instaddr_o, e.iaddr);
                chk("rd_addr_o", {27'd0, rd_addr_o}, {27'd0, e.rd});
                chk("regs_wen_o", {31'd0, regs_wen_o}, {31'd0, e.wen});
                chk("misalign_o", {31'd0, misalign_o}, {31'd0, e.mis});
                if (e.wen) chk("rd_data_o", rd_data_o, e.data);
            end
        end else if (rstn === 1'b0 && valid_o === 1'b0 && regs_wen_o !== 1'b0) begin
            chk("bubble_regs_wen", {31'd0, regs_wen_o}, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid_i       = 1'b0;
            dbus_rvalid_i = ($urandom_range(0, 3) == 0);   // stray rvalid must be ignored
            dbus_rdata_i  = $urandom;
            @(negedge clk);
            chk("idle_req", {31'd0, dbus_req_o}, 32'd0);
            step();
        end
        dbus_rvalid_i = 1'b0;
    endtask

    // mode: 0 normal, 1 flush while waiting for load data, 2 reset while waiting
    task automatic do_op(input logic [2:0] f3, input logic cs, input logic we,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdi,
                         input logic [31:0] rdat, input int gdly, input int rdly, input int mode);
        exp_t        e;
        logic        m;
        logic [31:0] ins;
        ins           = $urandom;
        ins[14:12]    = f3;
        valid_i       = 1'b1;
        inst_i        = ins;
        instaddr_i    = $urandom;
        cs_i          = cs;
        mem_we_i      = we;
        mem_addr_i    = a;
        mem_din_i     = d;
        regs_wen_i    = $urandom_range(0, 1);
        rd_addr_i     = 5'($urandom);
        rd_data_i     = rdi;
        flush_i       = 1'b0;
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        e.inst = ins; e.iaddr = instaddr_i; e.rd = rd_addr_i;
        e.data = rdi; e.wen = regs_wen_i; e.mis = 1'b0;
        m = cs && model_mis(f3, we, a);
        if (!cs) begin
            @(negedge clk);
            chk("alu_req", {31'd0, dbus_req_o}, 32'd0);
            chk("alu_ready", {31'd0, ready_o}, 32'd1);
            exp_q.push_back(e);
            step();
        end else if (m) begin
            @(negedge clk);
            chk("mis_req", {31'd0, dbus_req_o}, 32'd0);
            chk("mis_ready", {31'd0, ready_o}, 32'd1);
            e.wen = 1'b0; e.mis = 1'b1;
            exp_q.push_back(e);
            step();
        end else begin
            for (int k = 0; k < gdly; k++) begin
                @(negedge clk);
                chk("held_req", {31'd0, dbus_req_o}, 32'd1);
                chk("held_ready", {31'd0, ready_o}, 32'd0);
                step();
            end
            dbus_gnt_i = 1'b1;
            @(negedge clk);
            chk("req", {31'd0, dbus_req_o}, 32'd1);
            chk("we", {31'd0, dbus_we_o}, {31'd0, we});
            chk("be", {28'd0, dbus_be_o}, {28'd0, model_be(f3, we, a)});
            chk("addr", dbus_addr_o, a & ~32'd3);
            if (we) chk("wdata", dbus_wdata_o, model_wdata(f3, d));
            chk("gnt_ready", {31'd0, ready_o}, {31'd0, we});
            if (we) begin
                e.wen = 1'b0;
                exp_q.push_back(e);
                step();
                dbus_gnt_i = 1'b0;
            end else begin
                step();
                dbus_gnt_i = 1'b0;
                if (mode == 1) begin
                    flush_i = 1'b1;
                    @(negedge clk);
                    chk("flush_ready", {31'd0, ready_o}, 32'd0);
                    step();
                    flush_i = 1'b0;
                    valid_i = 1'b0;
                    for (int k = 0; k < rdly; k++) begin
                        @(negedge clk);
                        chk("drain_ready", {31'd0, ready_o}, 32'd0);
                        step();
                    end
                    dbus_rvalid_i = 1'b1;
                    dbus_rdata_i  = rdat;
                    @(negedge clk);
                    chk("drain_req", {31'd0, dbus_req_o}, 32'd0);
                    step();
                    dbus_rvalid_i = 1'b0;
                end else if (mode == 2) begin
                    valid_i = 1'b0;
                    rstn    = 1'b1;
                    step();
                    rstn          = 1'b0;
                    dbus_rvalid_i = 1'b1;
                    dbus_rdata_i  = rdat;
                    @(negedge clk);
                    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
                    chk("rst_regs_wen_o", {31'd0, regs_wen_o}, 32'd0);
                    chk("rst_misalign_o", {31'd0, misalign_o}, 32'd0);
                    chk("rst_inst_o", inst_o, 32'd0);
                    chk("rst_rd_data_o", rd_data_o, 32'd0);
                    chk("rst_idle_ready", {31'd0, ready_o}, 32'd1);
                    step();
                    dbus_rvalid_i = 1'b0;
                end else begin
                    for (int k = 0; k < rdly; k++) begin
                        @(negedge clk);
                        chk("wait_req", {31'd0, dbus_req_o}, 32'd0);
                        chk("wait_ready", {31'd0, ready_o}, 32'd0);
                        step();
                    end
                    dbus_rvalid_i = 1'b1;
                    dbus_rdata_i  = rdat;
                    e.data = model_load(f3, a, rdat);
                    @(negedge clk);
                    chk("rvalid_ready", {31'd0, ready_o}, 32'd1);
                    exp_q.push_back(e);
                    step();
                    dbus_rvalid_i = 1'b0;
                end
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic flush_idle;
        valid_i    = 1'b1;
        cs_i       = 1'b1;
        mem_we_i   = $urandom_range(0, 1);
        inst_i     = 32'h0000_2000;   // word access
        mem_addr_i = 32'h0000_4000;
        flush_i    = 1'b1;
        @(negedge clk);
        chk("flush_idle_req", {31'd0, dbus_req_o}, 32'd0);
        chk("flush_idle_ready", {31'd0, ready_o}, 32'd1);
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rstn = 1'b1;
        valid_i = 0; cs_i = 0; mem_we_i = 0; regs_wen_i = 0; flush_i = 0;
        inst_i = 0; instaddr_i = 0; mem_addr_i = 0; mem_din_i = 0; rd_data_i = 0;
        rd_addr_i = 0; dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("reset_valid_o", {31'd0, valid_o}, 32'd0);
        chk("reset_regs_wen_o", {31'd0, regs_wen_o}, 32'd0);
        chk("reset_misalign_o", {31'd0, misalign_o}, 32'd0);
        chk("reset_rd_data_o", rd_data_o, 32'd0);
        chk("reset_instaddr_o", instaddr_o, 32'd0);
        chk("reset_ready", {31'd0, ready_o}, 32'd1);
        step();

        // directed cases
        do_op(3'b000, 1, 1, 32'h1003, 32'h0000_00A5, 32'h1, 32'h0, 0, 0, 0);        // SB
        do_op(3'b001, 1, 0, 32'h2002, 32'h0, 32'h2, 32'h8001_1234, 0, 0, 0);        // LH
        do_op(3'b100, 1, 0, 32'h2001, 32'h0, 32'h3, 32'h0000_F000, 3, 0, 0);        // LBU
        do_op(3'b010, 1, 0, 32'h3002, 32'h0, 32'h4, 32'h0, 0, 0, 0);                // LW misaligned
        do_op(3'b010, 1, 0, 32'h3000, 32'h0, 32'h5, 32'hDEAD_BEEF, 0, 2, 1);        // flushed load
        idle(2);
        do_op(3'b101, 1, 0, 32'h3004, 32'h0, 32'h6, 32'h1234_5678, 1, 1, 2);        // reset mid-load
        do_op(3'b000, 0, 0, 32'h0, 32'h0, 32'h0000_0010, 32'h0, 0, 0, 0);           // ADDI passthrough
        flush_idle();

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0)      idle($urandom_range(1, 2));
            else if (kind == 1) flush_idle();
            else if (kind == 2) do_op(3'($urandom), 0, 1'($urandom), $urandom, $urandom, $urandom,
                                      $urandom, 0, 0, 0);
            else if (kind == 3) do_op(3'($urandom_range(0, 2)), 1, 0, $urandom & ~32'd3, 0, $urandom,
                                      $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 1);
            else                do_op(3'($urandom), 1, 1'($urandom), $urandom, $urandom, $urandom,
                                      $urandom, $urandom_range(0, 3), $urandom_range(0, 2), 0);
        end
        idle(3);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
